// File: rtl/memoria_datos_resp.sv
// Data memory with fixed response latency and a one-cycle completion pulse.
// Optional out-of-range address checking is enabled by defining MEM_ERR_DIR_EN.
module memoria_datos_resp #(
    parameter int LATENCIA = 2,
    parameter int PROF     = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        mem_wr,
    input  logic [31:0] dir_mem,
    input  logic [31:0] data,
    output logic [31:0] mem_out,
    output logic        ready,
    output logic        valid_out,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        ESPERA,
        RESP
    } estado_t;

    estado_t     state;
    estado_t     next_state;
    logic [3:0]  cnt;
    logic [7:0]  idx_q;
    logic [31:0] data_q;
    logic        wr_q;
    logic        access;
    logic        fuera;
    logic [31:0] array [PROF];

`ifdef MEM_ERR_DIR_EN
    logic dir_alta_q;
    logic err_q;

    assign fuera = dir_alta_q;
    assign err   = err_q & valid_out;
`else
    logic unused_dir_alta;

    assign unused_dir_alta = ^dir_mem[31:8];
    assign fuera           = 1'b0;
    assign err             = 1'b0;
`endif

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        valid_out  = 1'b0;
        access     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (req) begin
                    next_state = ESPERA;
                end
            end
            ESPERA: begin
                if (cnt == 4'd0) begin
                    access     = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                valid_out  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Request capture, latency countdown and read-data register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= 4'd0;
            idx_q   <= 8'd0;
            data_q  <= 32'd0;
            wr_q    <= 1'b0;
            mem_out <= 32'd0;
        end else begin
            if (state == IDLE && req) begin
                idx_q  <= dir_mem[7:0];
                data_q <= data;
                wr_q   <= mem_wr;
                cnt    <= 4'(LATENCIA - 1);
            end else if (state == ESPERA && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (access && !wr_q) begin
                mem_out <= fuera ? 32'd0 : array[idx_q];
            end
        end
    end

`ifdef MEM_ERR_DIR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir_alta_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (state == IDLE && req) begin
                dir_alta_q <= |dir_mem[31:8];
            end
            if (access) begin
                err_q <= dir_alta_q;
            end
        end
    end
`endif

    // The array has no reset so its contents survive reset_n.
    always_ff @(posedge clk) begin
        if (access && wr_q && !fuera) begin
            array[idx_q] <= data_q;
        end
    end

endmodule

// File: tb/tb_memoria_datos_resp.sv
// Scoreboard bench for memoria_datos_resp: instance 0 uses LATENCIA=2, instance 1 uses LATENCIA=1.
module tb_memoria_datos_resp;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

`ifdef MEM_ERR_DIR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        req_i   [2];
    logic        wr_i    [2];
    logic [31:0] dir_i   [2];
    logic [31:0] dat_i   [2];
    logic [31:0] out_o   [2];
    logic        ready_o [2];
    logic        valid_o [2];
    logic        err_o   [2];

    logic [31:0] model   [2][256];
    logic [31:0] exp_out [2];
    exp_t        sb [$];
    int          vectors;
    int          miscompares;

    memoria_datos_resp #(.LATENCIA(2), .PROF(256)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req_i[0]),
        .mem_wr    (wr_i[0]),
        .dir_mem   (dir_i[0]),
        .data      (dat_i[0]),
        .mem_out   (out_o[0]),
        .ready     (ready_o[0]),
        .valid_out (valid_o[0]),
        .err       (err_o[0])
    );

    memoria_datos_resp #(.LATENCIA(1), .PROF(256)) dut1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req_i[1]),
        .mem_wr    (wr_i[1]),
        .dir_mem   (dir_i[1]),
        .data      (dat_i[1]),
        .mem_out   (out_o[1]),
        .ready     (ready_o[1]),
        .valid_out (valid_o[1]),
        .err       (err_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request at the current falling edge and follows it to completion.
    task automatic do_req(input int sel, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit hold);
        int   lat;
        bit   oor;
        exp_t e;
        lat = (sel == 1) ? 1 : 2;
        oor = ERR_EN && (addr[31:8] != 24'd0);
        vectors++;
        if (ready_o[sel] !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_before_req dut%0d: got %b expected 1", sel, ready_o[sel]);
        end
        req_i[sel] = 1'b1;
        wr_i[sel]  = wr;
        dir_i[sel] = addr;
        dat_i[sel] = wdata;
        @(posedge clk);
        if (wr) begin
            if (!oor) model[sel][addr[7:0]] = wdata;
        end else begin
            exp_out[sel] = oor ? 32'd0 : model[sel][addr[7:0]];
        end
        e.data = exp_out[sel];
        e.err  = oor;
        sb.push_back(e);
        for (int m = 0; m <= lat + 1; m++) begin
            @(negedge clk);
            if (m == 0) begin
                if (hold) begin
                    req_i[sel] = 1'b1;
                    wr_i[sel]  = 1'b1;
                    dir_i[sel] = 32'h20;
                    dat_i[sel] = 32'h1;
                end else begin
                    req_i[sel] = 1'b0;
                    wr_i[sel]  = 1'($urandom);
                    dir_i[sel] = $urandom;
                    dat_i[sel] = $urandom;
                end
            end
            vectors++;
            if (valid_o[sel] !== (m == lat)) begin
                miscompares++;
                $display("FAIL valid_out dut%0d m=%0d: got %b expected %b", sel, m, valid_o[sel], (m == lat));
            end
            vectors++;
            if (ready_o[sel] !== (m > lat)) begin
                miscompares++;
                $display("FAIL ready dut%0d m=%0d: got %b expected %b", sel, m, ready_o[sel], (m > lat));
            end
            if (m == lat) begin
                e = sb.pop_front();
                vectors++;
                if (out_o[sel] !== e.data) begin
                    miscompares++;
                    $display("FAIL mem_out dut%0d addr=%h: got %h expected %h", sel, addr, out_o[sel], e.data);
                end
                vectors++;
                if (err_o[sel] !== e.err) begin
                    miscompares++;
                    $display("FAIL err dut%0d addr=%h: got %b expected %b", sel, addr, err_o[sel], e.err);
                end
                req_i[sel] = 1'b0;
            end
        end
    endtask

    // Starts a request on instance 0 and pulls reset during its wait phase.
    task automatic abort_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        req_i[0] = 1'b1;
        wr_i[0]  = wr;
        dir_i[0] = addr;
        dat_i[0] = wdata;
        @(posedge clk);
        #2;
        reset_n  = 1'b0;
        req_i[0] = 1'b0;
        exp_out[0] = 32'd0;
        exp_out[1] = 32'd0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 2) reset_n = 1'b1;
            for (int s = 0; s < 2; s++) begin
                vectors++;
                if (valid_o[s] !== 1'b0 || ready_o[s] !== 1'b1 || out_o[s] !== 32'd0) begin
                    miscompares++;
                    $display("FAIL abort dut%0d c=%0d: got valid=%b ready=%b mem_out=%h expected 0 1 00000000",
                             s, c, valid_o[s], ready_o[s], out_o[s]);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            req_i[s] = 1'b0;
            wr_i[s]  = 1'b0;
            dir_i[s] = 32'd0;
            dat_i[s] = 32'd0;
            exp_out[s] = 32'd0;
        end
        #3;
        for (int s = 0; s < 2; s++) begin
            vectors++;
            if (ready_o[s] !== 1'b1 || valid_o[s] !== 1'b0 || err_o[s] !== 1'b0 || out_o[s] !== 32'd0) begin
                miscompares++;
                $display("FAIL reset_state dut%0d: got ready=%b valid=%b err=%b mem_out=%h expected 1 0 0 00000000",
                         s, ready_o[s], valid_o[s], err_o[s], out_o[s]);
            end
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        do_req(0, 1'b1, 32'h30, 32'h12345678, 1'b0);
    endtask

    task automatic test_write_read();
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        do_req(0, 1'b0, 32'h10, 32'h0, 1'b0);
    endtask

    task automatic test_reset_abort();
        abort_req(1'b0, 32'h05, 32'h0);
        abort_req(1'b1, 32'h30, 32'h00000BAD);
        do_req(0, 1'b0, 32'h30, 32'h0, 1'b0);
    endtask

    task automatic test_busy();
        do_req(0, 1'b1, 32'h20, 32'hCAFE0020, 1'b0);
        do_req(0, 1'b0, 32'h10, 32'h0, 1'b1);
        do_req(0, 1'b0, 32'h20, 32'h0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_req(1, 1'b1, 32'h00, 32'h11111111, 1'b0);
        do_req(1, 1'b0, 32'h00, 32'h0, 1'b0);
        do_req(1, 1'b1, 32'h00, 32'h22222222, 1'b0);
        do_req(1, 1'b0, 32'h00, 32'h0, 1'b0);
    endtask

    task automatic test_addr_range();
        do_req(0, 1'b1, 32'h00000110, 32'h55, 1'b0);
        do_req(0, 1'b0, 32'h10, 32'h0, 1'b0);
        do_req(0, 1'b0, 32'h00000110, 32'h0, 1'b0);
    endtask

    task automatic test_integrity();
        do_req(0, 1'b1, 32'hFF, 32'hFFFFFFFF, 1'b0);
        do_req(0, 1'b1, 32'h00, 32'h00000000, 1'b0);
        do_req(0, 1'b0, 32'hFF, 32'h0, 1'b0);
        do_req(0, 1'b0, 32'h00, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        vectors++;
        if (out_o[0] !== exp_out[0]) begin
            miscompares++;
            $display("FAIL mem_out_hold: got %h expected %h", out_o[0], exp_out[0]);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_write_read();
        test_reset_abort();
        test_busy();
        test_back_to_back();
        test_addr_range();
        test_integrity();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
